// File: rtl/rst_seq_if.sv
// Reset sequencer bus: lock/software-request inputs toward the sequencer,
// staged resets and status back out. The sequencer connects as slave.
interface rst_seq_if #(
    parameter int NUM_STAGES = 3
);
    logic                  pll_lock;
    logic                  sw_rst_req;
    logic [NUM_STAGES-1:0] rst_stage;
    logic                  rst_done;
    logic [2:0]            seq_state;

    modport master (
        output pll_lock,
        output sw_rst_req,
        input  rst_stage,
        input  rst_done,
        input  seq_state
    );

    modport slave (
        input  pll_lock,
        input  sw_rst_req,
        output rst_stage,
        output rst_done,
        output seq_state
    );
endinterface

// File: rtl/rst_seq.sv
// Reset sequencer: waits for a filtered PLL lock, holds every domain in
// reset for a fixed time, then releases the domains one by one (bit 0
// first) with a fixed gap. Lock loss or a software request restarts it.
module rst_seq #(
    parameter int NUM_STAGES  = 3,
    parameter int LOCK_FILTER = 8,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    rst_seq_if.slave    bus
);
    localparam int LW = $clog2(LOCK_FILTER) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    state_t                state, state_n;
    logic [1:0]            rst_sync;
    logic                  lock_meta, lock_s;
    logic [LW-1:0]         lock_cnt, lock_n;
    logic [HW-1:0]         hold_cnt, hold_n;
    logic [GW-1:0]         gap_cnt, gap_n;
    logic [NUM_STAGES-1:0] stage, stage_n, stage_shift;
    logic                  done, done_n;

    // Reset release synchronizer: set asynchronously, drains to 0 on clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_sync <= 2'b11;
        else     rst_sync <= {rst_sync[0], 1'b0};
    end

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= bus.pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State, counters and outputs all registered so outputs come from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RESET;
            lock_cnt <= '0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            stage    <= '1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_n;
            hold_cnt <= hold_n;
            gap_cnt  <= gap_n;
            stage    <= stage_n;
            done     <= done_n;
        end
    end

    // Next-state logic; releasing shifts a zero in at bit 0, which keeps the
    // release order monotonic and reaches all-zero exactly at the last stage.
    always_comb begin
        state_n     = state;
        lock_n      = lock_cnt;
        hold_n      = hold_cnt;
        gap_n       = gap_cnt;
        stage_n     = stage;
        done_n      = done;
        stage_shift = stage << 1;
        case (state)
            ST_RESET: begin
                stage_n = '1;
                done_n  = 1'b0;
                lock_n  = '0;
                hold_n  = '0;
                gap_n   = '0;
                if (!rst_sync[1]) state_n = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                stage_n = '1;
                done_n  = 1'b0;
                if (!lock_s) begin
                    lock_n = '0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_n = ST_HOLD;
                    hold_n  = '0;
                    lock_n  = '0;
                end else begin
                    lock_n = lock_cnt + 1'b1;
                end
            end
            ST_HOLD, ST_RELEASE, ST_RUN: begin
                if (!lock_s) begin
                    state_n = ST_WAIT_LOCK;
                    lock_n  = '0;
                    stage_n = '1;
                    done_n  = 1'b0;
                end else if (bus.sw_rst_req) begin
                    state_n = ST_HOLD;
                    hold_n  = '0;
                    stage_n = '1;
                    done_n  = 1'b0;
                end else if (state == ST_HOLD) begin
                    if (hold_cnt == HOLD_LAST) begin
                        stage_n = stage_shift;
                        gap_n   = '0;
                        if (stage_shift == '0) begin
                            state_n = ST_RUN;
                            done_n  = 1'b1;
                        end else begin
                            state_n = ST_RELEASE;
                        end
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end else if (state == ST_RELEASE) begin
                    if (gap_cnt == GAP_LAST) begin
                        stage_n = stage_shift;
                        gap_n   = '0;
                        if (stage_shift == '0) begin
                            state_n = ST_RUN;
                            done_n  = 1'b1;
                        end
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = ST_RESET;
                lock_n  = '0;
                hold_n  = '0;
                gap_n   = '0;
                stage_n = '1;
                done_n  = 1'b0;
            end
        endcase
    end

    assign bus.rst_stage = stage;
    assign bus.rst_done  = done;
    assign bus.seq_state = state;
endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: a vector table of edge checkpoints drives the default
// instance through its timelines; a one-stage instance with minimum
// parameters runs alongside for the boundary case.
module tb_rst_seq;
    localparam int S_RESET = 0, S_WAIT = 1, S_HOLD = 2, S_REL = 3, S_RUN = 4;

    typedef struct {
        int         edge_no;
        logic       lock;
        logic       sw;
        int         st;
        logic [2:0] stg;
        logic       done;
    } vec_t;

    logic clk, rst, pll_lock, sw_rst_req, cur_lock;
    int   edge_n, total, passed, n_tl;
    vec_t vecs[$];
    vec_t sb[$];

    rst_seq_if #(.NUM_STAGES(3)) b1 ();
    rst_seq_if #(.NUM_STAGES(1)) b2 ();

    assign b1.pll_lock   = pll_lock;
    assign b1.sw_rst_req = sw_rst_req;
    assign b2.pll_lock   = pll_lock;
    assign b2.sw_rst_req = sw_rst_req;

    rst_seq dut (.clk(clk), .rst(rst), .bus(b1));

    rst_seq #(.NUM_STAGES(1), .LOCK_FILTER(1), .HOLD_CYCLES(2), .STAGE_GAP(1))
        dut_min (.clk(clk), .rst(rst), .bus(b2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void add(input int e, input logic lk, input logic sw,
                                input int st, input logic [2:0] stg, input logic dn);
        vecs.push_back('{e, lk, sw, st, stg, dn});
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, int'(b1.seq_state), S_RESET);
        check({tag, "_stage"}, int'(b1.rst_stage), 7);
        check({tag, "_done"},  int'(b1.rst_done), 0);
        check({tag, "_min_stage"}, int'(b2.rst_stage), 1);
    endtask

    // One clock edge; expected values go on the scoreboard as stimulus is driven.
    task automatic step(input logic lk, input logic sw, input bit has_exp, input vec_t v);
        vec_t e;
        pll_lock   = lk;
        sw_rst_req = sw;
        if (has_exp) sb.push_back(v);
        @(posedge clk);
        edge_n++;
        #1;
        if (has_exp) begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                check($sformatf("e%0d_state", e.edge_no), int'(b1.seq_state), e.st);
                check($sformatf("e%0d_stage", e.edge_no), int'(b1.rst_stage), int'(e.stg));
                check($sformatf("e%0d_done", e.edge_no),  int'(b1.rst_done), int'(e.done));
            end
        end
        if (edge_n == 3) check("min_e3_state", int'(b2.seq_state), S_WAIT);
        if (edge_n == 5) begin
            check("min_e5_state", int'(b2.seq_state), S_HOLD);
            check("min_e5_stage", int'(b2.rst_stage), 1);
        end
        if (edge_n == 6) begin
            check("min_e6_state", int'(b2.seq_state), S_RUN);
            check("min_e6_stage", int'(b2.rst_stage), 0);
            check("min_e6_done",  int'(b2.rst_done), 1);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        vec_t v;
        for (int i = lo; i < hi; i++) begin
            v = vecs[i];
            while (edge_n < v.edge_no - 1) step(cur_lock, 1'b0, 1'b0, v);
            step(v.lock, v.sw, 1'b1, v);
            cur_lock = v.lock;
        end
    endtask

    initial begin
        total = 0; passed = 0; edge_n = 0; cur_lock = 1'b1;
        rst = 1'b1; pll_lock = 1'b1; sw_rst_req = 1'b0;

        // Power-on timeline with lock held high.
        add(1, 1, 0, S_RESET, 3'b111, 0);  add(2, 1, 0, S_RESET, 3'b111, 0);
        add(3, 1, 0, S_WAIT, 3'b111, 0);   add(10, 1, 0, S_WAIT, 3'b111, 0);
        add(11, 1, 0, S_HOLD, 3'b111, 0);  add(26, 1, 0, S_HOLD, 3'b111, 0);
        add(27, 1, 0, S_REL, 3'b110, 0);   add(30, 1, 0, S_REL, 3'b110, 0);
        add(31, 1, 0, S_REL, 3'b100, 0);   add(34, 1, 0, S_REL, 3'b100, 0);
        add(35, 1, 0, S_RUN, 3'b000, 1);   add(40, 1, 0, S_RUN, 3'b000, 1);
        n_tl = vecs.size();
        // Software request from RUN, then again with lock loss during release.
        add(41, 1, 1, S_HOLD, 3'b111, 0);  add(42, 1, 0, S_HOLD, 3'b111, 0);
        add(56, 1, 0, S_HOLD, 3'b111, 0);  add(57, 1, 0, S_REL, 3'b110, 0);
        add(61, 1, 0, S_REL, 3'b100, 0);   add(65, 1, 0, S_RUN, 3'b000, 1);
        add(66, 1, 1, S_HOLD, 3'b111, 0);  add(67, 1, 0, S_HOLD, 3'b111, 0);
        add(82, 1, 0, S_REL, 3'b110, 0);   add(86, 1, 0, S_REL, 3'b100, 0);
        add(87, 0, 0, S_REL, 3'b100, 0);   add(88, 0, 0, S_REL, 3'b100, 0);
        add(89, 0, 0, S_WAIT, 3'b111, 0);  add(90, 0, 0, S_WAIT, 3'b111, 0);
        // Lock returns, glitches low once at lock_cnt=5, filter restarts.
        add(91, 1, 0, S_WAIT, 3'b111, 0);  add(95, 1, 0, S_WAIT, 3'b111, 0);
        add(96, 0, 0, S_WAIT, 3'b111, 0);  add(97, 1, 0, S_WAIT, 3'b111, 0);
        add(98, 1, 0, S_WAIT, 3'b111, 0);  add(105, 1, 0, S_WAIT, 3'b111, 0);
        add(106, 1, 0, S_HOLD, 3'b111, 0); add(121, 1, 0, S_HOLD, 3'b111, 0);
        add(122, 1, 0, S_REL, 3'b110, 0);
        // Lock loss and software request on the same edge: lock loss wins.
        add(123, 0, 0, S_REL, 3'b110, 0);  add(124, 0, 0, S_REL, 3'b110, 0);
        add(125, 0, 1, S_WAIT, 3'b111, 0); add(126, 0, 0, S_WAIT, 3'b111, 0);
        add(127, 1, 0, S_WAIT, 3'b111, 0); add(135, 1, 0, S_WAIT, 3'b111, 0);
        add(136, 1, 0, S_HOLD, 3'b111, 0); add(152, 1, 0, S_REL, 3'b110, 0);
        add(156, 1, 0, S_REL, 3'b100, 0);  add(160, 1, 0, S_RUN, 3'b000, 1);

        #1;
        check_reset_vals("por");
        @(posedge clk); @(posedge clk);
        #1;
        check_reset_vals("por_clocked");
        @(negedge clk); #4 rst = 1'b0;
        edge_n = 0;
        run_vecs(0, n_tl);
        run_vecs(n_tl, vecs.size());

        // Asynchronous reset pulse between edges while in RUN.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        #1 rst = 1'b0;
        edge_n = 0;
        cur_lock = 1'b1;
        run_vecs(0, n_tl);

        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high. Clock port is clk and reset port is rst.
REQ-002 Parameter NUM_STAGES, default 3, SHALL set the number of sequenced reset outputs; legal range 1..8.
REQ-003 Parameter LOCK_FILTER, default 8, SHALL set the consecutive synced pll_lock-high cycles needed before hold starts; legal range 1..255.
REQ-004 Parameter HOLD_CYCLES, default 16, SHALL set the cycles all resets stay asserted after lock is qualified; legal range 1..65535.
REQ-005 Parameter STAGE_GAP, default 4, SHALL set the cycles between successive stage releases; legal range 1..255.
REQ-006 Port clk  input  1  free-running clock.
REQ-007 Port rst  input  1  asynchronous active-high power-on reset.
REQ-008 Port pll_lock  input  1  asynchronous lock indication; synchronized internally.
REQ-009 Port sw_rst_req  input  1  synchronous software reset request, level-sampled each edge.
REQ-010 Port rst_stage  output  NUM_STAGES  active-high reset per downstream domain; bit 0 releases first.
REQ-011 Port rst_done  output  1  high only when all stages are released and the FSM is in RUN.
REQ-012 Port seq_state  output  3  current FSM state encoding.

Function
REQ-013 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from any input to rst_stage or rst_done.
REQ-014 Internal rst_sync SHALL be a 2-flop chain: async set by rst, clocked low; the FSM leaves RESET only on the edge after rst_sync reads 0.
REQ-015 pll_lock SHALL pass a 2-flop synchronizer (lock_s), async cleared by rst; all lock decisions SHALL use lock_s only.
REQ-016 States and encoding SHALL be: RESET=0, WAIT_LOCK=1, HOLD=2, RELEASE=3, RUN=4; the 5..7 encodings SHALL recover to RESET on the next edge.
REQ-017 RESET -> WAIT_LOCK SHALL occur when rst_sync=0; lock counter cleared.
REQ-018 In WAIT_LOCK, each edge with lock_s=1 SHALL increment lock_cnt; lock_s=0 SHALL clear it; the edge with lock_cnt==LOCK_FILTER-1 and lock_s=1 SHALL enter HOLD with hold_cnt=0.
REQ-019 In HOLD, hold_cnt SHALL increment each edge; the edge with hold_cnt==HOLD_CYCLES-1 SHALL enter RELEASE and clear rst_stage[0] on that same edge.
REQ-020 In RELEASE, a gap counter SHALL release stage k+1 exactly STAGE_GAP edges after stage k; the edge releasing bit NUM_STAGES-1 SHALL enter RUN and set rst_done. With NUM_STAGES=1, HOLD SHALL go straight to RUN.
REQ-021 Stage release SHALL be monotonic: bit k never deasserts while any bit below k is asserted.
REQ-022 In HOLD, RELEASE or RUN, lock_s=0 SHALL on the same edge set all rst_stage bits, clear rst_done and enter WAIT_LOCK with lock_cnt=0.
REQ-023 In HOLD, RELEASE or RUN with lock_s=1, sw_rst_req=1 SHALL on the same edge set all rst_stage bits, clear rst_done and enter HOLD with hold_cnt=0. sw_rst_req SHALL be ignored in RESET and WAIT_LOCK.
REQ-024 When lock loss and sw_rst_req coincide, lock loss SHALL take priority and the FSM enters WAIT_LOCK.
REQ-025 Counter widths SHALL be sized by $clog2 of the parameter value plus 1; counters SHALL never wrap.

Reset
REQ-026 While rst=1, asynchronously and without a clock: rst_stage all ones, rst_done=0, seq_state=RESET, rst_sync=2'b11, lock_s chain 0, all counters 0.
REQ-027 rst asserted mid-sequence, in any state, SHALL immediately force the REQ-026 values; deassertion SHALL restart the full sequence.

Verification
REQ-028 Defaults, pll_lock=1 held, rst falls before edge 1 -> WAIT_LOCK at edge 3, HOLD at edge 11, rst_stage 3'b110 at edge 27, 3'b100 at edge 31, 3'b000 with rst_done=1 at edge 35.
REQ-029 Defaults, pll_lock toggles low for 1 cycle at lock_cnt=5 in WAIT_LOCK -> lock_cnt clears; HOLD is entered only after 8 further consecutive lock_s-high edges.
REQ-030 In RUN, 1-cycle sw_rst_req -> rst_stage=3'b111 and rst_done=0 on the sampling edge; release repeats 16+4+4 edges later in stage order.
REQ-031 pll_lock drops while rst_stage=3'b100 -> all bits reassert within 2 edges plus 1 edge of synchronizer latency; FSM enters WAIT_LOCK.
REQ-032 In RELEASE, sw_rst_req=1 and lock_s=0 on the same edge -> seq_state=WAIT_LOCK, rst_stage=3'b111.
REQ-033 rst pulsed asynchronously between edges in RUN -> rst_stage=3'b111 and rst_done=0 before the next edge; after deassertion, the full REQ-028 timeline repeats.
